// File: rtl/stl_rst_seq.sv
// rtl/stl_rst_seq.sv - CPU reset sequencer: drain, hold, staged bus/core release
module stl_rst_seq #(
  parameter int HOLD_CYC = 16,
  parameter int GAP_CYC  = 8,
  parameter int DRAIN_TO = 256
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sw_rst_req,
  input  logic       i_wdt_rst_req,
  input  logic       i_bus_idle,
  output logic       o_drain_req,
  output logic       o_rst_n_bus,
  output logic       o_rst_n_core,
  output logic       o_busy,
  output logic [1:0] o_rst_cause
);

  // Counter must hold the largest terminal value of any timed state.
  localparam int MAX_HG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int MAX_C  = (MAX_HG > DRAIN_TO) ? MAX_HG : DRAIN_TO;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TO - 1);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_WDT  = 2'b10;
  localparam logic [1:0] CAUSE_DRTO = 2'b11;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    ASSERT  = 2'd2,
    REL_BUS = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Sequencer FSM; every output is set alongside the state it belongs to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ASSERT;
      cnt          <= '0;
      o_rst_n_bus  <= 1'b0;
      o_rst_n_core <= 1'b0;
      o_drain_req  <= 1'b0;
      o_busy       <= 1'b1;
      o_rst_cause  <= CAUSE_POR;
    end else begin
      case (state)
        RUN: begin
          if (i_wdt_rst_req) begin
            // Watchdog skips the drain: the bus may be hung.
            state        <= ASSERT;
            cnt          <= '0;
            o_rst_n_bus  <= 1'b0;
            o_rst_n_core <= 1'b0;
            o_busy       <= 1'b1;
            o_rst_cause  <= CAUSE_WDT;
          end else if (i_sw_rst_req) begin
            state       <= DRAIN;
            cnt         <= '0;
            o_drain_req <= 1'b1;
            o_busy      <= 1'b1;
            o_rst_cause <= CAUSE_SW;
          end
        end

        DRAIN: begin
          if (i_wdt_rst_req || i_bus_idle || (cnt == DRAIN_LAST)) begin
            state        <= ASSERT;
            cnt          <= '0;
            o_drain_req  <= 1'b0;
            o_rst_n_bus  <= 1'b0;
            o_rst_n_core <= 1'b0;
            if (i_wdt_rst_req) begin
              o_rst_cause <= CAUSE_WDT;
            end else if (!i_bus_idle) begin
              o_rst_cause <= CAUSE_DRTO;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ASSERT: begin
          if (cnt == HOLD_LAST) begin
            state       <= REL_BUS;
            cnt         <= '0;
            o_rst_n_bus <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        REL_BUS: begin
          if (cnt == GAP_LAST) begin
            state        <= RUN;
            cnt          <= '0;
            o_rst_n_core <= 1'b1;
            o_busy       <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state        <= ASSERT;
          cnt          <= '0;
          o_rst_n_bus  <= 1'b0;
          o_rst_n_core <= 1'b0;
          o_drain_req  <= 1'b0;
          o_busy       <= 1'b1;
        end
      endcase
    end
  end

endmodule
